// File: rtl/jtoutrun_obj_prefetch.sv
// Sequential OBJ ROM prefetcher: walks the bank-3 ROM slot one word at a time
// and queues the words in a show-ahead FIFO for the object renderer.
module jtoutrun_obj_prefetch #(
  parameter int FIFO_AW = 3,
  parameter int AW      = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AW-1:0]      start_addr,
  input  logic [7:0]         start_len,
  input  logic               abort,
  output logic               busy,
  input  logic               rd,
  output logic [15:0]        dout,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               obj_cs,
  output logic [AW-1:0]      obj_addr,
  input  logic               obj_ok,
  input  logic [15:0]        obj_data
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE = (FIFO_AW+1)'(1);

  typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;

  state_t             state, state_nx;
  logic [7:0]         remain, remain_nx;
  logic [AW-1:0]      addr_nx;
  logic               push, pop, flush, full;
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;

  assign full   = (level == DEPTH_L);
  assign empty  = (level == '0);
  assign dout   = mem[rd_ptr];
  assign busy   = (state != IDLE);
  assign obj_cs = (state != IDLE);
  assign pop    = rd && !empty && !flush;

  // Fullness uses the registered level, so a same-cycle pop never makes room.
  always_comb begin
    state_nx  = state;
    remain_nx = remain;
    addr_nx   = obj_addr;
    push      = 1'b0;
    flush     = 1'b0;
    if (abort) begin
      state_nx  = IDLE;
      remain_nx = '0;
      flush     = 1'b1;
    end else if (start) begin
      flush = 1'b1;
      if (start_len != 8'd0) begin
        state_nx  = REQ;
        remain_nx = start_len;
        addr_nx   = start_addr;
      end else begin
        state_nx  = IDLE;
        remain_nx = '0;
      end
    end else begin
      case (state)
        REQ: begin
          if (obj_ok && !full) begin
            push      = 1'b1;
            addr_nx   = obj_addr + AW'(1);
            remain_nx = remain - 8'd1;
            state_nx  = (remain == 8'd1) ? IDLE : SETTLE;
          end
        end
        // The slot's ok may still describe the previous address here.
        SETTLE:  state_nx = REQ;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      remain   <= '0;
      obj_addr <= '0;
    end else begin
      state    <= state_nx;
      remain   <= remain_nx;
      obj_addr <= addr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= obj_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_jtoutrun_obj_prefetch.sv
// Randomized bench for jtoutrun_obj_prefetch against a queue-based burst model
// and a ROM slot model with configurable ok latency and stale-ok behaviour.
module tb_jtoutrun_obj_prefetch;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort, rd, obj_ok;
  logic [19:0] start_addr;
  logic [7:0]  start_len;
  logic [15:0] obj_data;
  logic        busy, empty, obj_cs;
  logic [15:0] dout;
  logic [3:0]  level;
  logic [19:0] obj_addr;

  jtoutrun_obj_prefetch #(.FIFO_AW(3), .AW(20)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .start_len(start_len), .abort(abort), .busy(busy), .rd(rd),
    .dout(dout), .empty(empty), .level(level), .obj_cs(obj_cs),
    .obj_addr(obj_addr), .obj_ok(obj_ok), .obj_data(obj_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // burst model: pending request address, words left, dead cycle after a capture
  logic [15:0] q[$];
  logic [19:0] m_addr;
  int          m_remain;
  bit          m_active, m_dead, last_cap;

  // slot model
  int          lat, age;
  bit          stale_mode;
  logic [19:0] last_addr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit st, input logic [19:0] sa, input logic [7:0] sl,
                           input bit ab, input bit r, input bit ok, input logic [15:0] d);
    bit cap;
    cap = 1'b0;
    if (ab) begin
      q.delete();
      m_active = 0;
      m_dead   = 0;
    end else if (st) begin
      q.delete();
      m_dead = 0;
      if (sl != 0) begin
        m_active = 1;
        m_addr   = sa;
        m_remain = sl;
      end else begin
        m_active = 0;
      end
    end else begin
      cap = m_active && !m_dead && ok && (q.size() < DEPTH);
      if (r && q.size() > 0) void'(q.pop_front());
      if (cap) begin
        q.push_back(d);
        m_addr = m_addr + 20'd1;
        m_remain--;
        if (m_remain == 0) m_active = 0;
      end
      m_dead = cap;
    end
    last_cap = cap;
  endtask

  task automatic applyStimulus(input bit st, input logic [19:0] sa, input logic [7:0] sl,
                               input bit ab, input bit r);
    bit          stale, ok;
    logic [15:0] d;
    if (!obj_cs || obj_addr != last_addr) age = 0;
    else age++;
    stale = stale_mode && last_cap && (age == 0);
    ok    = obj_cs && ((age >= lat) || stale);
    d     = stale ? last_addr[15:0] : obj_addr[15:0];
    last_addr  = obj_addr;
    start      = st;
    start_addr = sa;
    start_len  = sl;
    abort      = ab;
    rd         = r;
    obj_ok     = ok;
    obj_data   = d;
    modelStep(st, sa, sl, ab, r, ok, d);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("busy",     32'(busy),     32'(m_active));
    checkOutput("obj_cs",   32'(obj_cs),   32'(m_active));
    checkOutput("obj_addr", 32'(obj_addr), 32'(m_addr));
    checkOutput("level",    32'(level),    32'(q.size()));
    checkOutput("empty",    32'(empty),    32'(q.size() == 0));
    if (q.size() > 0) checkOutput("dout", 32'(dout), 32'(q[0]));
  endtask

  task automatic idleCycles(input int n, input bit r);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, r);
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; rd = 0; obj_ok = 0;
    start_addr = '0; start_len = '0; obj_data = '0;
    m_addr = '0; m_remain = 0; m_active = 0; m_dead = 0; last_cap = 0;
    lat = 0; age = 0; stale_mode = 0; last_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy",   32'(busy),     32'd0);
    checkOutput("rst_cs",     32'(obj_cs),   32'd0);
    checkOutput("rst_addr",   32'(obj_addr), 32'd0);
    checkOutput("rst_level",  32'(level),    32'd0);
    checkOutput("rst_empty",  32'(empty),    32'd1);
    checkOutput("rst_dout",   32'(dout),     32'd0);
    rst = 1'b0;

    // zero-wait slot, four words, no reads
    lat = 0;
    applyStimulus(1, 20'h00010, 8'd4, 0, 0);
    idleCycles(10, 0);
    checkOutput("t1_level", 32'(level), 32'd4);
    checkOutput("t1_head",  32'(dout),  32'h0010);
    checkOutput("t1_busy",  32'(busy),  32'd0);

    // slow slot with reader always pulling
    lat = 5;
    applyStimulus(1, 20'h00010, 8'd3, 0, 1);
    idleCycles(30, 1);
    checkOutput("t2_empty", 32'(empty), 32'd1);

    // stale ok after each address change
    lat = 2; stale_mode = 1;
    applyStimulus(1, 20'h00040, 8'd6, 0, 1);
    idleCycles(40, 1);
    stale_mode = 0;

    // FIFO full stall and refill after one pop
    lat = 0;
    applyStimulus(1, 20'h00100, 8'd12, 0, 0);
    idleCycles(25, 0);
    checkOutput("t4_level", 32'(level),    32'd8);
    checkOutput("t4_cs",    32'(obj_cs),   32'd1);
    checkOutput("t4_addr",  32'(obj_addr), 32'h00108);
    applyStimulus(0, '0, '0, 0, 1);
    applyStimulus(0, '0, '0, 0, 0);
    checkOutput("t4_refill", 32'(obj_addr), 32'h00109);
    idleCycles(40, 1);
    checkOutput("t4_done", 32'(busy), 32'd0);

    // address wrap
    applyStimulus(1, 20'hFFFFE, 8'd4, 0, 0);
    idleCycles(12, 0);
    checkOutput("t5_level", 32'(level),    32'd4);
    checkOutput("t5_addr",  32'(obj_addr), 32'h00002);
    idleCycles(6, 1);

    // abort with simultaneous start, then restart mid-burst
    applyStimulus(1, 20'h00200, 8'd10, 0, 0);
    for (int i = 0; i < 20 && level != 4'd3; i++) applyStimulus(0, '0, '0, 0, 0);
    checkOutput("t6_level3", 32'(level), 32'd3);
    applyStimulus(1, 20'h00300, 8'd5, 1, 1);
    checkOutput("t6_level", 32'(level),  32'd0);
    checkOutput("t6_busy",  32'(busy),   32'd0);
    checkOutput("t6_cs",    32'(obj_cs), 32'd0);
    applyStimulus(1, 20'h00200, 8'd10, 0, 0);
    idleCycles(5, 0);
    applyStimulus(1, 20'h00500, 8'd3, 0, 1);
    checkOutput("t6_restart", 32'(obj_addr), 32'h00500);
    idleCycles(20, 1);

    // randomized bursts
    for (int b = 0; b < 40; b++) begin
      int          rdpct, len;
      logic [19:0] sa;
      lat        = $urandom_range(0, 5);
      stale_mode = 1'($urandom_range(0, 1));
      rdpct      = $urandom_range(30, 100);
      len        = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      sa         = ($urandom_range(0, 3) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15))
                                               : 20'($urandom);
      applyStimulus(1, sa, 8'(len), 0, ($urandom_range(1, 100) <= rdpct));
      for (int c = 0; c < 400; c++) begin
        bit ab, st, r;
        if (!m_active && q.size() == 0) break;
        ab = ($urandom_range(0, 199) == 0);
        st = ($urandom_range(0, 149) == 0);
        r  = ($urandom_range(1, 100) <= rdpct);
        applyStimulus(st, 20'($urandom), 8'($urandom_range(0, 12)), ab, r);
      end
      checkOutput("burst_done",  32'(busy),  32'd0);
      checkOutput("burst_level", 32'(level), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
